db_write_ctrl: RTL

Write-side controller for the 64-byte USB endpoint data buffer. It accepts byte-store requests from the AHB-Lite slave (TX data) and the USB RX packet path, then issues registered write strobes, addresses and data to the buffer RAM. It also keeps the authoritative buffer occupancy count that the read controller consumes. It sits beside the buffer's read controller and observes its `read_en` pulses to decrement occupancy.

---
 rtl/db_write_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/db_write_ctrl.sv
// Write-side controller for the USB endpoint data buffer: registered RAM write port plus occupancy tracking.
// Optional sticky overflow flag is enabled by defining DB_WRITE_OVERFLOW_FLAG_EN.
module db_write_ctrl #(
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              store_rx_data,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              read_en,
    input  logic              clear,
    input  logic              flush,
    output logic              write_en,
    output logic [PTR_W-2:0]  write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [PTR_W-1:0]  write_ptr,
    output logic [PTR_W-1:0]  buff_occ,
    output logic              buff_full,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        FULL   = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);

    state_t            state_q, state_d;
    logic              write_en_q, write_en_d;
    logic [PTR_W-2:0]  write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [PTR_W-1:0]  write_ptr_q, write_ptr_d;
    logic [PTR_W-1:0]  buff_occ_q, buff_occ_d;
    logic              overflow_q, overflow_d;

    logic wipe;
    logic store_req;
    logic accept;
    logic dec;

    // clear/flush dominate everything else in the same cycle
    assign wipe      = clear | flush;
    assign store_req = store_rx_data | store_tx_data;
    assign accept    = store_req && (state_q != FULL) && !wipe;
    assign dec       = read_en && (buff_occ_q != '0) && !wipe;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        if (wipe) begin
            state_d = IDLE;
        end else if (buff_occ_d == DEPTH_V) begin
            state_d = FULL;
        end else if (accept) begin
            state_d = ACCEPT;
        end else begin
            state_d = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        buff_full = (state_q == FULL);
        dbg_state = state_q;
    end

    // Datapath next values
    always_comb begin
        write_en_d   = accept;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_ptr_d  = write_ptr_q;
        buff_occ_d   = buff_occ_q;

        if (accept) begin
            write_addr_d = write_ptr_q[PTR_W-2:0];
            // rx has priority; a simultaneous tx byte is dropped
            write_data_d = store_rx_data ? rx_data : tx_data;
            write_ptr_d  = write_ptr_q + 1'b1;
        end

        if (wipe) begin
            write_ptr_d = '0;
            buff_occ_d  = '0;
        end else if (accept && !dec) begin
            buff_occ_d = buff_occ_q + 1'b1;
        end else if (dec && !accept) begin
            buff_occ_d = buff_occ_q - 1'b1;
        end
    end

`ifdef DB_WRITE_OVERFLOW_FLAG_EN
    always_comb begin
        overflow_d = overflow_q;
        if (wipe) begin
            overflow_d = 1'b0;
        end else if (store_req && (state_q == FULL)) begin
            overflow_d = 1'b1;
        end
    end
`else
    always_comb begin
        overflow_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            write_ptr_q  <= '0;
            buff_occ_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            write_ptr_q  <= write_ptr_d;
            buff_occ_q   <= buff_occ_d;
            overflow_q   <= overflow_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign write_ptr  = write_ptr_q;
    assign buff_occ   = buff_occ_q;
    assign overflow   = overflow_q;

endmodule
